// File: rtl/uart_receive.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling from a baud counter,
// output byte register with valid/ack handshake plus framing and overrun flags.
module uart_receive #(
    parameter int ClkFreq = 50000000,
    parameter int B_Rate  = 9600
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       Serial_In,
    input  logic       R_ACK,
    output logic [7:0] Data,
    output logic       Data_Valid,
    output logic       Receive_Done,
    output logic       Frame_Error,
    output logic       Overrun,
    output logic       Busy
);
    localparam int          CLKS_PER_BIT = ClkFreq / B_Rate;
    localparam int          HALF_BIT     = CLKS_PER_BIT / 2;
    localparam logic [31:0] BIT_LAST     = 32'(CLKS_PER_BIT - 1);
    localparam logic [31:0] HALF_LAST    = 32'(HALF_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK_WAIT} state_t;

    state_t      state, state_n;
    logic        rx_meta, rx_s;
    logic [31:0] clk_count, clk_count_n;
    logic [31:0] bit_idx, bit_idx_n;
    logic [7:0]  shift_reg, shift_n;
    logic [7:0]  data_n;
    logic        valid_n, done_n, ferr_n, overrun_n;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            rx_meta      <= 1'b1;
            rx_s         <= 1'b1;
            state        <= IDLE;
            clk_count    <= '0;
            bit_idx      <= '0;
            shift_reg    <= '0;
            Data         <= '0;
            Data_Valid   <= 1'b0;
            Receive_Done <= 1'b0;
            Frame_Error  <= 1'b0;
            Overrun      <= 1'b0;
        end else begin
            rx_meta      <= Serial_In;
            rx_s         <= rx_meta;
            state        <= state_n;
            clk_count    <= clk_count_n;
            bit_idx      <= bit_idx_n;
            shift_reg    <= shift_n;
            Data         <= data_n;
            Data_Valid   <= valid_n;
            Receive_Done <= done_n;
            Frame_Error  <= ferr_n;
            Overrun      <= overrun_n;
        end
    end

    always_comb begin
        state_n     = state;
        clk_count_n = clk_count;
        bit_idx_n   = bit_idx;
        shift_n     = shift_reg;
        data_n      = Data;
        valid_n     = Data_Valid;
        overrun_n   = Overrun;
        done_n      = 1'b0;
        ferr_n      = 1'b0;

        if (R_ACK) begin
            valid_n   = 1'b0;
            overrun_n = 1'b0;
        end

        case (state)
            IDLE: begin
                clk_count_n = '0;
                bit_idx_n   = '0;
                if (!rx_s) state_n = START;
            end
            START: begin
                // A high line at mid-start is treated as a glitch, not a frame.
                if (clk_count == HALF_LAST) begin
                    clk_count_n = '0;
                    state_n     = rx_s ? IDLE : DATA;
                end else begin
                    clk_count_n = clk_count + 32'd1;
                end
            end
            DATA: begin
                if (clk_count == BIT_LAST) begin
                    clk_count_n           = '0;
                    shift_n[bit_idx[2:0]] = rx_s;
                    if (bit_idx == 32'd7) begin
                        bit_idx_n = '0;
                        state_n   = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 32'd1;
                    end
                end else begin
                    clk_count_n = clk_count + 32'd1;
                end
            end
            STOP: begin
                if (clk_count == BIT_LAST) begin
                    clk_count_n = '0;
                    if (rx_s) begin
                        // A simultaneous ack consumes the old byte, so no overrun.
                        data_n  = shift_reg;
                        done_n  = 1'b1;
                        valid_n = 1'b1;
                        if (Data_Valid && !R_ACK) overrun_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = BREAK_WAIT;
                    end
                end else begin
                    clk_count_n = clk_count + 32'd1;
                end
            end
            BREAK_WAIT: begin
                clk_count_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign Busy = (state != IDLE);
endmodule

// File: tb/tb_uart_receive.sv
// Directed bench for uart_receive at 10 clocks per bit; a negedge monitor
// tallies output pulses and each scenario task checks its own expectations.
module tb_uart_receive;
    logic       Clk = 1'b0;
    logic       reset = 1'b0;
    logic       Serial_In = 1'b1;
    logic       R_ACK = 1'b0;
    logic [7:0] Data;
    logic       Data_Valid, Receive_Done, Frame_Error, Overrun, Busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    int ferr_cnt = 0;
    int busy_cnt = 0;
    int done_cyc = 0;
    int t_fall   = 0;
    logic [7:0] rx_q[$];

    uart_receive #(.ClkFreq(1000), .B_Rate(100)) dut (
        .Clk(Clk), .reset(reset), .Serial_In(Serial_In), .R_ACK(R_ACK),
        .Data(Data), .Data_Valid(Data_Valid), .Receive_Done(Receive_Done),
        .Frame_Error(Frame_Error), .Overrun(Overrun), .Busy(Busy)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (Receive_Done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            rx_q.push_back(Data);
        end
        if (Frame_Error) ferr_cnt = ferr_cnt + 1;
        if (Busy) busy_cnt = busy_cnt + 1;
    end

    // ack_mode: 0 none, 1 one-cycle ack after Receive_Done, 2 ack on the completion edge
    task automatic send_frame(input logic [7:0] b, input logic stop_lvl,
                              input int stop_cycles, input int ack_mode);
        logic ack_nxt;
        ack_nxt = 1'b0;
        t_fall  = cyc;
        for (int k = 0; k < 90 + stop_cycles; k++) begin
            if (k < 10)      Serial_In = 1'b0;
            else if (k < 90) Serial_In = b[(k-10)/10];
            else             Serial_In = stop_lvl;
            R_ACK   = ack_nxt || (ack_mode == 2 && k == 97);
            ack_nxt = 1'b0;
            @(posedge Clk); #1;
            if (ack_mode == 1 && Receive_Done) ack_nxt = 1'b1;
        end
        R_ACK = ack_nxt;
        if (ack_nxt) begin
            @(posedge Clk); #1;
            R_ACK = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        n_checks++; if (Data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", Data); end
        n_checks++; if ({Data_Valid, Receive_Done, Frame_Error, Overrun, Busy} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 00000", {Data_Valid, Receive_Done, Frame_Error, Overrun, Busy}); end
        reset = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", Busy); end
    endtask

    task automatic test_single();
        int d0, lat;
        d0 = done_cnt;
        send_frame(8'hA5, 1'b1, 10, 0);
        lat = done_cyc - t_fall;
        n_checks++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL single_done_cnt: got %0d expected %0d", done_cnt, d0 + 1); end
        n_checks++; if (lat < 96 || lat > 98) begin n_fail++; $display("FAIL single_latency: got %0d expected 96..98", lat); end
        n_checks++; if (Data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", Data); end
        repeat (3) @(posedge Clk);
        #1;
        n_checks++; if (Data_Valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_hold: got %b expected 1", Data_Valid); end
        R_ACK = 1'b1;
        @(posedge Clk); #1;
        R_ACK = 1'b0;
        n_checks++; if (Data_Valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_ack: got %b expected 0", Data_Valid); end
        n_checks++; if (Data !== 8'hA5) begin n_fail++; $display("FAIL single_data_after_ack: got %h expected a5", Data); end
    endtask

    task automatic test_back_to_back();
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        rx_q.delete();
        send_frame(8'h3C, 1'b1, 10, 1);
        send_frame(8'hC3, 1'b1, 10, 1);
        repeat (2) @(posedge Clk);
        #1;
        n_checks++; if (done_cnt !== d0 + 2) begin n_fail++; $display("FAIL b2b_done_cnt: got %0d expected %0d", done_cnt, d0 + 2); end
        n_checks++; if (rx_q.size() != 2 || rx_q[0] !== 8'h3C || rx_q[1] !== 8'hC3) begin
            n_fail++; $display("FAIL b2b_order: got %0d bytes expected 3c,c3", rx_q.size()); end
        n_checks++; if (Overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %b expected 0", Overrun); end
        n_checks++; if (ferr_cnt !== f0) begin n_fail++; $display("FAIL b2b_ferr: got %0d expected %0d", ferr_cnt, f0); end
        n_checks++; if (Data_Valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid: got %b expected 0", Data_Valid); end
    endtask

    task automatic test_start_glitch();
        int d0, f0, b0;
        d0 = done_cnt; f0 = ferr_cnt; b0 = busy_cnt;
        Serial_In = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Serial_In = 1'b1;
        repeat (20) @(posedge Clk);
        #1;
        n_checks++; if (busy_cnt - b0 < 1 || busy_cnt - b0 > 6) begin
            n_fail++; $display("FAIL glitch_busy_cycles: got %0d expected 1..6", busy_cnt - b0); end
        n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL glitch_done: got %0d expected %0d", done_cnt, d0); end
        n_checks++; if (ferr_cnt !== f0) begin n_fail++; $display("FAIL glitch_ferr: got %0d expected %0d", ferr_cnt, f0); end
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got %b expected 0", Busy); end
    endtask

    task automatic test_frame_error();
        int d0, f0;
        d0 = done_cnt; f0 = ferr_cnt;
        send_frame(8'h55, 1'b0, 40, 0);
        n_checks++; if (ferr_cnt !== f0 + 1) begin n_fail++; $display("FAIL ferr_pulse: got %0d expected %0d", ferr_cnt, f0 + 1); end
        n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL ferr_no_done: got %0d expected %0d", done_cnt, d0); end
        n_checks++; if (Data !== 8'hC3 || Data_Valid !== 1'b0) begin
            n_fail++; $display("FAIL ferr_data_kept: got %h/%b expected c3/0", Data, Data_Valid); end
        n_checks++; if (Busy !== 1'b1) begin n_fail++; $display("FAIL ferr_break_wait: got %b expected 1", Busy); end
        Serial_In = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL ferr_release: got %b expected 0", Busy); end
        send_frame(8'h0F, 1'b1, 10, 1);
        n_checks++; if (done_cnt !== d0 + 1 || Data !== 8'h0F) begin
            n_fail++; $display("FAIL ferr_next_frame: got %0d/%h expected %0d/0f", done_cnt, Data, d0 + 1); end
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1, 10, 0);
        send_frame(8'h22, 1'b1, 10, 0);
        n_checks++; if (Data !== 8'h22) begin n_fail++; $display("FAIL ovr_data: got %h expected 22", Data); end
        n_checks++; if ({Data_Valid, Overrun} !== 2'b11) begin n_fail++; $display("FAIL ovr_flags: got %b expected 11", {Data_Valid, Overrun}); end
        R_ACK = 1'b1;
        @(posedge Clk); #1;
        R_ACK = 1'b0;
        n_checks++; if ({Data_Valid, Overrun} !== 2'b00) begin n_fail++; $display("FAIL ovr_ack_clear: got %b expected 00", {Data_Valid, Overrun}); end
        send_frame(8'h44, 1'b1, 10, 0);
        n_checks++; if ({Data_Valid, Overrun} !== 2'b10) begin n_fail++; $display("FAIL ovr_pre_same: got %b expected 10", {Data_Valid, Overrun}); end
        send_frame(8'h33, 1'b1, 10, 2);
        n_checks++; if (Data !== 8'h33) begin n_fail++; $display("FAIL ovr_same_data: got %h expected 33", Data); end
        n_checks++; if ({Data_Valid, Overrun} !== 2'b10) begin n_fail++; $display("FAIL ovr_same_cycle: got %b expected 10", {Data_Valid, Overrun}); end
    endtask

    task automatic test_reset_mid_frame();
        int d0;
        for (int k = 0; k < 45; k++) begin
            Serial_In = (k < 10) ? 1'b0 : 1'b1;
            @(posedge Clk); #1;
        end
        #3 reset = 1'b0;
        #1;
        n_checks++; if (Data !== 8'h00) begin n_fail++; $display("FAIL midrst_data: got %h expected 00", Data); end
        n_checks++; if ({Data_Valid, Receive_Done, Frame_Error, Overrun, Busy} !== 5'b0) begin
            n_fail++; $display("FAIL midrst_flags: got %b expected 00000", {Data_Valid, Receive_Done, Frame_Error, Overrun, Busy}); end
        Serial_In = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        reset = 1'b1;
        d0 = done_cnt;
        repeat (120) @(posedge Clk);
        #1;
        n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL midrst_spurious: got %0d expected %0d", done_cnt, d0); end
        send_frame(8'h81, 1'b1, 10, 0);
        n_checks++; if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL midrst_done: got %0d expected %0d", done_cnt, d0 + 1); end
        n_checks++; if (Data !== 8'h81 || Data_Valid !== 1'b1) begin
            n_fail++; $display("FAIL midrst_data_after: got %h/%b expected 81/1", Data, Data_Valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_start_glitch();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
